// File: rtl/matrix_stream_seq_if.sv
// Bus bundle between the matrix stream sequencer and its neighbours:
// host input stream, controller/datapath write and read paths, and the
// consumer output stream. The sequencer uses the master view.
interface matrix_stream_seq_if #(
    parameter int DATA_MSB = 31
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_MSB:0]   in_data;

    logic                we;
    logic [DATA_MSB:0]   wr_data_to_dp;

    logic                dp_dvalid;
    logic [DATA_MSB:0]   rd_data_from_dp;
    logic                re;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_MSB:0]   out_data;
    logic                out_row_last;
    logic                out_last;

    modport master (
        input  in_valid, in_data, dp_dvalid, rd_data_from_dp, out_ready,
        output in_ready, we, wr_data_to_dp, re,
               out_valid, out_data, out_row_last, out_last
    );

    modport slave (
        output in_valid, in_data, dp_dvalid, rd_data_from_dp, out_ready,
        input  in_ready, we, wr_data_to_dp, re,
               out_valid, out_data, out_row_last, out_last
    );
endinterface

// File: rtl/matrix_stream_seq.sv
// Host-side sequencer for the matrix read/write controller.
// LOAD turns an input stream into row-major we pulses; READ replays the
// stored matrix through a 2-entry FIFO so out_ready never reaches re.
module matrix_stream_seq #(
    parameter int DATA_MSB         = 31,
    parameter int MAT_IDX_SIZE_MSB = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start_load,
    input  logic                      start_read,
    input  logic [MAT_IDX_SIZE_MSB:0] row_idx_size,
    input  logic [MAT_IDX_SIZE_MSB:0] col_idx_size,
    matrix_stream_seq_if.master       bus,
    output logic                      busy,
    output logic                      done,
    output logic                      err_start
);
    localparam int IW = MAT_IDX_SIZE_MSB + 1;
    localparam int TW = 2 * IW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Sizes latched at start, and the element position of the next transfer.
    logic [IW-1:0] row_size, col_size;
    logic [IW-1:0] row_cnt, col_cnt;
    logic [TW-1:0] total, issued;

    // Two-entry output FIFO: payload plus row/matrix end tags.
    logic [DATA_MSB:0] fifo_data     [2];
    logic [1:0]        fifo_row_last;
    logic [1:0]        fifo_last;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;

    logic accept, push, pop;
    logic at_row_end, at_mat_end;
    logic load_fin, read_fin;
    logic err_nxt;

    // Handshake decode and datapath-facing outputs.
    always_comb begin
        at_row_end = (col_cnt == col_size);
        at_mat_end = at_row_end && (row_cnt == row_size);

        bus.in_ready      = (state == LOAD);
        accept            = bus.in_ready && bus.in_valid;
        bus.we            = accept;
        bus.wr_data_to_dp = bus.in_data;

        // The full check ignores a same-cycle pop, keeping out_ready off the re path.
        bus.re = (state == READ) && bus.dp_dvalid &&
                 (fifo_cnt < 2'd2) && (issued < total);
        push   = bus.re;

        bus.out_valid    = (fifo_cnt != 2'd0);
        bus.out_data     = fifo_data[rd_ptr];
        bus.out_row_last = bus.out_valid && fifo_row_last[rd_ptr];
        bus.out_last     = bus.out_valid && fifo_last[rd_ptr];
        pop              = bus.out_valid && bus.out_ready;

        load_fin = accept && at_mat_end;
        read_fin = pop && fifo_last[rd_ptr];
        busy     = (state != IDLE);
    end

    // Next-state and start-error decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                err_nxt = start_load && start_read;
                if (start_load)      state_nxt = LOAD;
                else if (start_read) state_nxt = READ;
            end
            LOAD: begin
                err_nxt = start_load || start_read;
                if (load_fin) state_nxt = IDLE;
            end
            READ: begin
                err_nxt = start_load || start_read;
                if (read_fin) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the one-cycle done / err_start pulses.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state     <= IDLE;
            done      <= 1'b0;
            err_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= load_fin || read_fin;
            err_start <= err_nxt;
        end
    end

    // Size latch at operation start; row-major position and issue count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_size <= '0;
            col_size <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            total    <= '0;
            issued   <= '0;
        end else if ((state == IDLE) && (start_load || start_read)) begin
            row_size <= row_idx_size;
            col_size <= col_idx_size;
            row_cnt  <= '0;
            col_cnt  <= '0;
            issued   <= '0;
            total    <= (TW'(row_idx_size) + TW'(1)) * (TW'(col_idx_size) + TW'(1));
        end else if (accept || push) begin
            if (at_row_end) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
            if (push) issued <= issued + 1'b1;
        end
    end

    // FIFO pointers and occupancy; a push with a pop leaves the count alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage written on each issued read, tagged with row/matrix end.
    always_ff @(posedge CLK) begin
        // NOTE: storage is not reset; the occupancy count alone decides what is valid.
        if (push) begin
            fifo_data[wr_ptr]     <= bus.rd_data_from_dp;
            fifo_row_last[wr_ptr] <= at_row_end;
            fifo_last[wr_ptr]     <= at_mat_end;
        end
    end
endmodule

// File: tb/tb_matrix_stream_seq.sv
// Directed bench for matrix_stream_seq: load, streaming readback,
// backpressure, start errors, 1x1 matrix and mid-read reset.
module tb_matrix_stream_seq;
    logic        CLK;
    logic        RST;
    logic        start_load, start_read;
    logic [3:0]  row_idx_size, col_idx_size;
    logic        busy, done, err_start;

    matrix_stream_seq_if #(.DATA_MSB(31)) bus ();

    matrix_stream_seq #(.DATA_MSB(31), .MAT_IDX_SIZE_MSB(3)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start_load   (start_load),
        .start_read   (start_read),
        .row_idx_size (row_idx_size),
        .col_idx_size (col_idx_size),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err_start    (err_start)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Small matrix controller/datapath model: stores written words, presents
    // the next stored word while dp_dvalid is set, advances on re.
    logic [31:0] mem [16];
    logic [3:0]  wr_m, rd_m;
    logic        dp_en;
    int          n_we = 0, n_re = 0, n_done = 0, n_overlap = 0;

    assign bus.dp_dvalid       = dp_en;
    assign bus.rd_data_from_dp = mem[rd_m];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_m <= '0;
            rd_m <= '0;
        end else begin
            if (start_load && !busy) wr_m <= '0;
            else if (bus.we)         wr_m <= wr_m + 4'd1;
            if (start_read && !busy) rd_m <= '0;
            else if (bus.re)         rd_m <= rd_m + 4'd1;
        end
    end

    always @(posedge CLK) begin
        if (bus.we && !(start_load && !busy)) mem[wr_m] <= bus.wr_data_to_dp;
    end

    always @(posedge CLK) begin
        if (bus.we)          n_we   <= n_we + 1;
        if (bus.re)          n_re   <= n_re + 1;
        if (done)            n_done <= n_done + 1;
        if (bus.we && bus.re) n_overlap <= n_overlap + 1;
    end

    task automatic start_op(input logic ld, input logic rd, input logic [3:0] r,
                            input logic [3:0] c, input logic exp_err);
        @(negedge CLK);
        start_load   = ld;
        start_read   = rd;
        row_idx_size = r;
        col_idx_size = c;
        @(negedge CLK);
        start_load = 1'b0;
        start_read = 1'b0;
        #1;
        check("err_start", err_start, exp_err);
    endtask

    task automatic feed(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            bus.in_valid = 1'b1;
            bus.in_data  = base + 32'(k);
            #1;
            check($sformatf("ld%0d_in_ready", k), bus.in_ready, 1'b1);
            check($sformatf("ld%0d_we", k), bus.we, 1'b1);
            check($sformatf("ld%0d_wdata", k), bus.wr_data_to_dp, base + 32'(k));
        end
        @(negedge CLK);
        bus.in_valid = 1'b0;
        #1;
        check("ld_done", done, 1'b1);
        check("ld_busy_low", busy, 1'b0);
        check("ld_in_ready_low", bus.in_ready, 1'b0);
        check("ld_we_low", bus.we, 1'b0);
        @(negedge CLK);
        #1;
        check("ld_done_pulse_end", done, 1'b0);
    endtask

    task automatic drain(input int n_pop, input int n_tot, input int cols,
                         input logic [31:0] base, input bit chk_end, input bit chk_b2b);
        int k = 0;
        int first_c = 0;
        int last_c = 0;
        for (int cyc = 0; cyc < 40 && k < n_pop; cyc++) begin
            @(negedge CLK);
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                check($sformatf("rd%0d_data", k), bus.out_data, base + 32'(k));
                check($sformatf("rd%0d_row_last", k), bus.out_row_last, (k % cols) == cols - 1);
                check($sformatf("rd%0d_last", k), bus.out_last, k == n_tot - 1);
                if (k == 0) first_c = cyc;
                last_c = cyc;
                k++;
            end
        end
        check("rd_pop_count", k, n_pop);
        if (chk_b2b) check("rd_b2b_span", last_c - first_c, n_pop - 1);
        if (chk_end) begin
            @(negedge CLK);
            #1;
            check("rd_done", done, 1'b1);
            check("rd_busy_low", busy, 1'b0);
            check("rd_fifo_empty", bus.out_valid, 1'b0);
            @(negedge CLK);
            #1;
            check("rd_done_pulse_end", done, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, re0, done0;
        RST           = 1'b1;
        start_load    = 1'b0;
        start_read    = 1'b0;
        row_idx_size  = '0;
        col_idx_size  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        dp_en         = 1'b0;

        // Reset state.
        repeat (2) @(negedge CLK);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_we", bus.we, 1'b0);
        check("rst_re", bus.re, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_row_last", bus.out_row_last, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err_start, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // 2x3 load of 1..6.
        we0 = n_we;
        start_op(1'b1, 1'b0, 4'd1, 4'd2, 1'b0);
        check("load_busy", busy, 1'b1);
        feed(6, 32'd1);
        check("load_we_count", n_we - we0, 6);

        // 2x3 streaming readback at one element per cycle.
        re0   = n_re;
        dp_en = 1'b1;
        start_op(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
        drain(6, 6, 3, 32'd1, 1'b1, 1'b1);
        check("read_re_count", n_re - re0, 6);

        // Readback with the consumer stalled for five cycles.
        bus.out_ready = 1'b0;
        re0 = n_re;
        start_op(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
        repeat (5) @(negedge CLK);
        #1;
        check("stall_re_count", n_re - re0, 2);
        check("stall_re_now", bus.re, 1'b0);
        check("stall_out_valid", bus.out_valid, 1'b1);
        check("stall_head", bus.out_data, 32'd1);
        drain(6, 6, 3, 32'd1, 1'b1, 1'b1);
        check("stall_re_total", n_re - re0, 6);

        // Both starts together in IDLE, then start_read during LOAD.
        bus.out_ready = 1'b0;
        re0 = n_re;
        start_op(1'b1, 1'b1, 4'd1, 4'd2, 1'b1);
        check("both_in_load", bus.in_ready, 1'b1);
        @(negedge CLK);
        #1;
        check("both_err_end", err_start, 1'b0);
        start_op(1'b0, 1'b1, 4'd3, 4'd3, 1'b1);
        check("busy_start_re", bus.re, 1'b0);
        @(negedge CLK);
        #1;
        check("busy_err_end", err_start, 1'b0);
        feed(6, 32'd1);
        check("err_no_re", n_re - re0, 0);

        // 1x1 load then read.
        we0   = n_we;
        re0   = n_re;
        done0 = n_done;
        start_op(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        feed(1, 32'd42);
        bus.out_ready = 1'b0;
        start_op(1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        drain(1, 1, 1, 32'd42, 1'b1, 1'b0);
        check("one_we", n_we - we0, 1);
        check("one_re", n_re - re0, 1);
        check("one_done", n_done - done0, 2);

        // Reset mid-read after three pops, then a clean read.
        start_op(1'b1, 1'b0, 4'd1, 4'd2, 1'b0);
        feed(6, 32'd1);
        bus.out_ready = 1'b0;
        start_op(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
        drain(3, 6, 3, 32'd1, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_out_last", bus.out_last, 1'b0);
        check("mid_rst_re", bus.re, 1'b0);
        check("mid_rst_done", done, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        bus.out_ready = 1'b0;
        start_op(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
        drain(6, 6, 3, 32'd1, 1'b1, 1'b1);

        check("we_re_overlap", n_overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/matrix_stream_seq.md
Name: matrix_stream_seq

Overview:
- Host-side sequencer that drives the we/re control interface of the matrix read/write controller.
- Converts a valid/ready input stream into a row-major matrix load (we pulses plus write data), and replays a stored matrix as a valid/ready output stream.
- On readback, datapath output words go into a 2-entry output FIFO, so the consumer's ready never combinationally reaches re.
- Sits between the top-level host/AXI-stream shim and the matrix controller/datapath pair.

Parameters:
DATA_MSB, 31, MSB of matrix element data
MAT_IDX_SIZE_MSB, 3, MSB of row/col index-size fields; must match the matrix controller

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
start_load  in  1  pulse: begin loading a matrix
start_read  in  1  pulse: begin reading a matrix back
row_idx_size  in  MAT_IDX_SIZE_MSB+1  last row index (rows = value+1); sampled at start
col_idx_size  in  MAT_IDX_SIZE_MSB+1  last col index (cols = value+1); sampled at start
in_valid  in  1  input element valid
in_ready  out  1  input element accepted when in_valid & in_ready
in_data  in  DATA_MSB+1  input element
we  out  1  write enable to matrix controller
wr_data_to_dp  out  DATA_MSB+1  write data to datapath; equals in_data
dp_dvalid  in  1  datapath read output holds a valid element
rd_data_from_dp  in  DATA_MSB+1  datapath read output
re  out  1  read enable to matrix controller; consumes the current datapath element
out_valid  out  1  output element valid
out_ready  in  1  consumer ready
out_data  out  DATA_MSB+1  FIFO head element
out_row_last  out  1  head element is the last column of its row
out_last  out  1  head element is the final element of the matrix
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a load or read completes
err_start  out  1  one-cycle pulse when a start is ignored

Behaviour:
- State machine: IDLE, LOAD, READ. On RST all state clears. Reset values: state=IDLE; in_ready, we, re, out_valid, out_row_last, out_last, busy, done, err_start = 0; FIFO empty; counters 0.
- IDLE transitions:
  - start_load -> LOAD.
  - start_read (without start_load) -> READ.
  - Both asserted: LOAD wins and err_start pulses next cycle.
  - Entering either state latches row/col sizes and clears row/col counters.
- start_load or start_read while busy: ignored; err_start pulses the next cycle; the operation in progress is unaffected.
- LOAD:
  - in_ready=1 (combinational on state only).
  - we = in_valid & in_ready; wr_data_to_dp = in_data (combinational, same cycle).
  - Each accept: col+1. At col==col_size: col wraps to 0 and row+1.
  - Accept of element (row_size, col_size): next state IDLE, done=1 for exactly one cycle after that edge. in_ready deasserts in that same cycle.
- READ, issue side:
  - re = dp_dvalid & (fifo_cnt < 2) & (issued < total).
  - total = (row_idx_size+1)*(col_idx_size+1), computed in 2*(MAT_IDX_SIZE_MSB+1)+1 bits.
  - On re, rd_data_from_dp is written into the FIFO at that clock edge, tagged with row_last (col==col_size) and last (final element). Issue counters advance.
  - The no-issue-when-full gate holds even if a pop happens the same cycle. A sustained 1 element/cycle is still achieved at fifo_cnt=1.
- READ, output side:
  - out_valid = fifo_cnt != 0. out_data, out_row_last, out_last come from the head entry.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop leaves fifo_cnt unchanged.
  - Pop of the out_last entry: next state IDLE, done pulses one cycle later, FIFO is empty.
- we and re are never asserted in the same cycle. re is 0 outside READ and we is 0 outside LOAD.
- 1x1 matrix (sizes 0,0): a single element, which is both row_last and last.
- Size inputs changing mid-operation have no effect.
- RST mid-operation: immediate return to IDLE and FIFO discarded. The matrix controller shares the same reset so its counters realign.

Test Plan:
- 2x3 load (row_idx_size=1, col_idx_size=2), in_valid held 1, data 1..6 -> we high exactly 6 cycles, wr_data_to_dp=1..6; done pulses once 1 cycle after the 6th accept; busy falls with it.
- 2x3 read, dp_dvalid=1, out_ready=1 -> out_data=1..6 back-to-back at 1/cycle; out_row_last on 3 and 6; out_last only on 6; done after pop of 6.
- Read with out_ready=0 for 5 cycles -> exactly 2 re pulses; FIFO full, out_valid=1, head=1 held; releasing out_ready drains in order with no loss or duplication.
- start_read during LOAD, and start_load & start_read together in IDLE -> err_start one-cycle pulse each time; LOAD proceeds; no re.
- 1x1 load then read -> one we, one re; out_row_last=out_last=1 on the single element; two done pulses total.
- RST asserted mid-READ after 3 of 6 pops -> outputs immediately at reset values, FIFO empty; a new start_read afterwards reads from element 1.
